conv_arbiter: RTL
=================

# conv_arbiter

Round-robin arbiter that shares one int-to-float converter between `N_REQ` requesters over stb/ack handshakes. It accepts one operand at a time from a granted requester and forwards it to the converter. It collects the converted result and returns it to the same requester, then rotates priority. It sits between the CPU's conversion clients (issue slots, DMA, test port) and the single converter instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of grant index; must equal clog2(`N_REQ`), minimum 1.

Ports:
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_a` in 32×`N_REQ`: packed operands; requester i occupies bits [32i+31:32i].
- `req_a_stb` in `N_REQ`: operand valid, one bit per requester.
- `req_a_ack` out `N_REQ`: operand accepted, one bit per requester.
- `rsp_z` out 32: result bus, shared by all requesters.
- `rsp_z_stb` out `N_REQ`: result valid, one-hot.
- `rsp_z_ack` in `N_REQ`: result taken, one bit per requester.
- `conv_a` out 32: operand to the converter.
- `conv_a_stb` out 1: operand valid to the converter.
- `conv_a_ack` in 1: converter ready for an operand.
- `conv_z` in 32: converter result.
- `conv_z_stb` in 1: converter result valid.
- `conv_z_ack` out 1: arbiter ready for the result.
- `busy` out 1: high in every state except ARB.
- `grant_id` out `ID_W`: index of the current or last granted requester.

## Operation
- Handshake rule on every channel: the sender raises stb and holds data stable until the transfer. A transfer happens in any cycle where stb and ack are both high. Both sides deassert in the following cycle.
- States: ARB, TAKE, ISSUE, COLLECT, RETURN.
- ARB:
  - If any `req_a_stb` is high, pick the first set bit at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - Register the choice into `grant_id`, set `req_a_ack[grant_id]`, go to TAKE.
  - If no stb is high, stay in ARB.
- TAKE:
  - On `req_a_stb[g] & req_a_ack[g]`: latch `req_a[g]` into `op`, clear the ack, go to ISSUE.
  - If the requester dropped stb (protocol violation), clear the ack and return to ARB without changing `rr_ptr`.
- ISSUE:
  - Drive `conv_a = op` and `conv_a_stb = 1`.
  - On `conv_a_stb & conv_a_ack`: clear stb, go to COLLECT.
- COLLECT:
  - Drive `conv_z_ack = 1`.
  - On `conv_z_stb & conv_z_ack`: latch `conv_z` into `res`, clear the ack, go to RETURN.
- RETURN:
  - Drive `rsp_z = res` and set `rsp_z_stb[g] = 1`.
  - On `rsp_z_ack[g]`: clear stb, set `rr_ptr = (g+1) mod N_REQ`, go to ARB.
- At most one conversion is outstanding. A requester's new stb during another's transaction waits in ARB.
- `rsp_z_ack` bits for non-granted requesters are ignored.
- `rsp_z` holds its last value outside RETURN.
- Reset values: state ARB, `rr_ptr` 0, `grant_id` 0, all stb/ack outputs 0, `busy` 0, `conv_a` 0, `rsp_z` 0.
- Reset mid-operation abandons the transaction; no response is issued. The converter must be reset in the same cycle, and the integrator handles the polarity conversion.

## Timing
- From `req_a_stb` rising with the arbiter idle: `req_a_ack` is high after 1 cycle, and the operand is captured at the end of the next cycle.
- `conv_a_stb` rises the cycle after capture.
- Arbiter overhead outside the converter is 5 cycles minimum per transaction: ARB, TAKE, ISSUE, COLLECT entry, RETURN.
- Round-robin fairness: under continuous requests from all requesters, each is served once per `N_REQ` transactions.
- If a stb and an existing `rr_ptr` target arrive in the same ARB cycle, the standard search order applies. There is no special case.

## Configuration
- `CONV_ARB_FIXED_PRIO_EN`:
  - When defined: fixed priority, lowest index wins, and `rr_ptr` is neither built nor updated.
  - When undefined: round-robin as described above.

## Test plan
- Requester 0 sends 0x00000001, others idle -> `rsp_z_stb[0]` with `rsp_z` = 0x3F800000; `grant_id` = 0.
- Requesters 1 and 3 assert together with operands 0xFFFFFFFF and 0x00000000, `rr_ptr` = 0 -> requester 1 is served first with 0xBF800000, then requester 3 with 0x00000000.
- All 4 requesters assert continuously with operand 0x01000001 -> grant order 0,1,2,3,0. Every result is 0x4B800000 (round-to-even). With `CONV_ARB_FIXED_PRIO_EN` defined, requester 0 is served every time.
- Requester 2 holds `rsp_z_ack` low for 10 cycles in RETURN -> `rsp_z_stb[2]` and `rsp_z` stay stable, no new grant, `busy` = 1.
- `rst` pulsed during COLLECT -> the next cycle has all outputs at reset values and no response. A following request from requester 0 with 0x00000002 returns 0x40000000.
- Requester 1 drops stb during TAKE -> `req_a_ack[1]` clears, state returns to ARB, converter untouched.

Source files
------------

// File: rtl/conv_arbiter.sv
// conv_arbiter: round-robin arbiter sharing one int-to-float converter among
// N_REQ requesters over stb/ack handshakes, one conversion in flight at a time.
// Optional build macro CONV_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins),
// no rotating pointer. Default build (macro undefined) is round-robin.
module conv_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [32*N_REQ-1:0] req_a,
   input  logic [N_REQ-1:0]    req_a_stb,
   output logic [N_REQ-1:0]    req_a_ack,
   output logic [31:0]         rsp_z,
   output logic [N_REQ-1:0]    rsp_z_stb,
   input  logic [N_REQ-1:0]    rsp_z_ack,
   output logic [31:0]         conv_a,
   output logic                conv_a_stb,
   input  logic                conv_a_ack,
   input  logic [31:0]         conv_z,
   input  logic                conv_z_stb,
   output logic                conv_z_ack,
   output logic                busy,
   output logic [ID_W-1:0]     grant_id
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      ST_ARB     = 3'd0,
      ST_TAKE    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_COLLECT = 3'd3,
      ST_RETURN  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [N_REQ-1:0]    req_a_ack_q, req_a_ack_d;
   logic [DATA_W-1:0]   rsp_z_q, rsp_z_d;
   logic [N_REQ-1:0]    rsp_z_stb_q, rsp_z_stb_d;
   logic [DATA_W-1:0]   conv_a_q, conv_a_d;
   logic                conv_a_stb_q, conv_a_stb_d;
   logic                conv_z_ack_q, conv_z_ack_d;
   logic                busy_q, busy_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
`ifndef CONV_ARB_FIXED_PRIO_EN
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

   logic [DATA_W-1:0]   req_op_c [N_REQ];
   logic [ID_W-1:0]     base_c;
   logic                any_req_c;
   logic [ID_W-1:0]     pick_id_c;
   logic                take_fire_c;
   logic                take_drop_c;
   logic                issue_fire_c;
   logic                collect_fire_c;
   logic                return_fire_c;

   // Unpacked view of the packed operand bus
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_op
      assign req_op_c[gi] = req_a[DATA_W*gi +: DATA_W];
   end

`ifdef CONV_ARB_FIXED_PRIO_EN
   assign base_c = '0;
`else
   assign base_c = rr_ptr_q;
`endif

   // Handshake completions for the granted requester and the converter
   assign take_fire_c    = (state_q == ST_TAKE) && req_a_stb[grant_id_q] && req_a_ack_q[grant_id_q];
   assign take_drop_c    = (state_q == ST_TAKE) && !req_a_stb[grant_id_q];
   assign issue_fire_c   = (state_q == ST_ISSUE) && conv_a_stb_q && conv_a_ack;
   assign collect_fire_c = (state_q == ST_COLLECT) && conv_z_ack_q && conv_z_stb;
   assign return_fire_c  = (state_q == ST_RETURN) && rsp_z_stb_q[grant_id_q] && rsp_z_ack[grant_id_q];

   // Search for the first requesting index at or after the base, wrapping
   always_comb begin
      int unsigned      idx;
      logic [ID_W-1:0]  cand;
      any_req_c = 1'b0;
      pick_id_c = '0;
      idx       = 0;
      cand      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 32'(base_c) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = ID_W'(idx);
         if (!any_req_c && req_a_stb[cand]) begin
            any_req_c = 1'b1;
            pick_id_c = cand;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_ARB;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ARB:     if (any_req_c) state_d = ST_TAKE;
         ST_TAKE: begin
            if (take_fire_c)      state_d = ST_ISSUE;
            else if (take_drop_c) state_d = ST_ARB;
         end
         ST_ISSUE:   if (issue_fire_c)   state_d = ST_COLLECT;
         ST_COLLECT: if (collect_fire_c) state_d = ST_RETURN;
         ST_RETURN:  if (return_fire_c)  state_d = ST_ARB;
         default:    state_d = ST_ARB;
      endcase
   end

   // Next values for the registered outputs and datapath
   always_comb begin
      req_a_ack_d  = req_a_ack_q;
      rsp_z_d      = rsp_z_q;
      rsp_z_stb_d  = rsp_z_stb_q;
      conv_a_d     = conv_a_q;
      conv_a_stb_d = conv_a_stb_q;
      conv_z_ack_d = conv_z_ack_q;
      grant_id_d   = grant_id_q;
`ifndef CONV_ARB_FIXED_PRIO_EN
      rr_ptr_d     = rr_ptr_q;
`endif
      busy_d       = (state_d != ST_ARB);
      unique case (state_q)
         ST_ARB: begin
            if (any_req_c) begin
               grant_id_d             = pick_id_c;
               req_a_ack_d            = '0;
               req_a_ack_d[pick_id_c] = 1'b1;
            end
         end
         ST_TAKE: begin
            if (take_fire_c) begin
               conv_a_d     = req_op_c[grant_id_q];
               conv_a_stb_d = 1'b1;
               req_a_ack_d  = '0;
            end else if (take_drop_c) begin
               req_a_ack_d  = '0;
            end
         end
         ST_ISSUE: begin
            if (issue_fire_c) begin
               conv_a_stb_d = 1'b0;
               conv_z_ack_d = 1'b1;
            end
         end
         ST_COLLECT: begin
            if (collect_fire_c) begin
               rsp_z_d                 = conv_z;
               conv_z_ack_d            = 1'b0;
               rsp_z_stb_d             = '0;
               rsp_z_stb_d[grant_id_q] = 1'b1;
            end
         end
         ST_RETURN: begin
            if (return_fire_c) begin
               rsp_z_stb_d = '0;
`ifndef CONV_ARB_FIXED_PRIO_EN
               if (32'(grant_id_q) == N_REQ - 1) rr_ptr_d = '0;
               else                              rr_ptr_d = grant_id_q + ID_W'(1);
`endif
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         req_a_ack_q  <= '0;
         rsp_z_q      <= '0;
         rsp_z_stb_q  <= '0;
         conv_a_q     <= '0;
         conv_a_stb_q <= 1'b0;
         conv_z_ack_q <= 1'b0;
         busy_q       <= 1'b0;
         grant_id_q   <= '0;
`ifndef CONV_ARB_FIXED_PRIO_EN
         rr_ptr_q     <= '0;
`endif
      end else begin
         req_a_ack_q  <= req_a_ack_d;
         rsp_z_q      <= rsp_z_d;
         rsp_z_stb_q  <= rsp_z_stb_d;
         conv_a_q     <= conv_a_d;
         conv_a_stb_q <= conv_a_stb_d;
         conv_z_ack_q <= conv_z_ack_d;
         busy_q       <= busy_d;
         grant_id_q   <= grant_id_d;
`ifndef CONV_ARB_FIXED_PRIO_EN
         rr_ptr_q     <= rr_ptr_d;
`endif
      end
   end

   assign req_a_ack  = req_a_ack_q;
   assign rsp_z      = rsp_z_q;
   assign rsp_z_stb  = rsp_z_stb_q;
   assign conv_a     = conv_a_q;
   assign conv_a_stb = conv_a_stb_q;
   assign conv_z_ack = conv_z_ack_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;

endmodule
